layer_sequencer: RTL and testbench
==================================

// Module: layer_sequencer
// PURPOSE
// Sequences one fully-connected layer of sigmoid/ReLU neuron instances. Buffers an input
// vector from the upstream layer and broadcasts it word-by-word to all neurons in parallel.
// Collects every neuron's result, then serialises the results to the downstream layer.
// Sits between two layers in the digit-recognition pipeline. One sequencer per layer.
// PARAMETERS
// IN_SIZE      784  words per input vector (equals each neuron's weight count)
// NUM_NEURONS  30   neurons driven by this sequencer
// DATA_WIDTH   16   fixed-point word width
// TIMEOUT      64   max cycles in WAIT before error (>=8)
// PORTS
// clk            in   1                    clock, rising edge
// rst            in   1                    asynchronous reset, active-high
// in_valid       in   1                    upstream word valid
// in_ready       out  1                    sequencer accepts upstream word
// in_data        in   DATA_WIDTH           upstream word
// nrn_in_valid   out  1                    broadcast valid to all neurons
// nrn_in         out  DATA_WIDTH           broadcast word to all neurons
// nrn_out_valid  in   NUM_NEURONS          per-neuron result valid pulse
// nrn_out        in   NUM_NEURONS*DATA_WIDTH  neuron i result at [i*DATA_WIDTH +: DATA_WIDTH]
// out_valid      out  1                    downstream word valid
// out_ready      in   1                    downstream accepts word
// out_data       out  DATA_WIDTH           result word, neuron 0 first
// out_last       out  1                    high with the result word of neuron NUM_NEURONS-1
// busy           out  1                    high in every state except LOAD
// err_timeout    out  1                    sticky; set on WAIT timeout, cleared only by rst
// BEHAVIOUR
// - Reset: state=LOAD, all counters/mask=0, result regs=0.
//   Outputs: in_ready=1, nrn_in_valid=0, nrn_in=0, out_valid=0, out_data=0, out_last=0, busy=0, err_timeout=0.
//   Input buffer contents are not reset. Reset mid-operation aborts immediately, with no partial output.
//   The neuron instances' own resets are driven by top level and are outside this block.
// - FSM: LOAD -> BCAST -> WAIT -> DRAIN -> LOAD. All outputs are registered.
// - LOAD: in_ready=1. On in_valid&in_ready, buf[ld_cnt]<=in_data and ld_cnt++.
//   The accept with ld_cnt==IN_SIZE-1 clears ld_cnt, deasserts in_ready next cycle and enters BCAST.
// - BCAST: nrn_in_valid=1 for exactly IN_SIZE consecutive cycles.
//   nrn_in=buf[0..IN_SIZE-1] in order. The first word appears the cycle after the last LOAD accept.
//   There are no bubbles, and neurons give no backpressure.
//   After the last word: nrn_in_valid=0, nrn_in holds its last value, and the FSM enters WAIT.
// - On entering WAIT: mask=0, result regs=0, tmo_cnt=0.
// - WAIT: for each bit i with nrn_out_valid[i]=1, res[i]<=nrn_out slice i and mask[i]<=1.
//   Any arrival order is allowed, and several bits may be high in the same cycle.
//   A repeated pulse for a set bit overwrites res[i].
//   Once mask is all-ones (including bits set this cycle), the next state is DRAIN.
//   tmo_cnt increments each WAIT cycle. At tmo_cnt==TIMEOUT-1 without a full mask:
//   err_timeout<=1 and the FSM enters DRAIN with missing results left at 0.
// - nrn_out_valid pulses outside WAIT are ignored.
// - DRAIN: out_valid=1, out_data=res[dr_cnt], out_last=(dr_cnt==NUM_NEURONS-1).
//   dr_cnt advances only on out_valid&out_ready. out_data and out_last stay stable while out_ready=0.
//   The handshake with out_last=1 clears dr_cnt, drops out_valid next cycle and returns to LOAD.
//   There is no LOAD/DRAIN overlap: in_ready=0 during BCAST, WAIT and DRAIN.
// - Counter widths are $clog2(IN_SIZE), $clog2(NUM_NEURONS) and $clog2(TIMEOUT). No wrap beyond the terminal values.
// - Throughput per vector: IN_SIZE load + IN_SIZE broadcast + neuron latency (~6) + NUM_NEURONS drain cycles, minimum.
// TESTING (IN_SIZE=4, NUM_NEURONS=3, TIMEOUT=16 unless noted)
// 1 Feed 1,2,3,4 back-to-back. Expect nrn_in_valid high 4 cycles starting the cycle after the 4th accept.
//   Expect nrn_in=1,2,3,4 and in_ready=0 from the cycle after the 4th accept.
// 2 Pulse nrn_out_valid=3'b111 with outputs 10,20,30 and out_ready=1.
//   Expect out_data 10,20,30 on consecutive cycles, out_last only on 30, then in_ready=1.
// 3 Pulse valids 3'b010, then 3'b001, then 3'b100 on separate cycles.
//   Expect no out_valid until after the third pulse, then correct order 0,1,2 with no error.
// 4 Toggle out_ready 1/0 during DRAIN.
//   Expect out_data/out_last held stable while ready=0, no word lost or duplicated, 3 handshakes total.
// 5 Give only bit0 valid (value 7) in WAIT.
//   After 16 WAIT cycles expect err_timeout=1 and output 7,0,0. err_timeout stays 1 into the next vector.
// 6 Assert rst in BCAST after 2 words.
//   Expect nrn_in_valid=0, in_ready=1, busy=0 immediately. A fresh vector then runs scenario 1 correctly.

Source files
------------

// File: rtl/layer_sequencer.sv
// Layer sequencer: buffers one input vector, broadcasts it to all neurons,
// collects their results and streams them downstream, neuron 0 first.
module layer_sequencer #(
  parameter int IN_SIZE     = 784,
  parameter int NUM_NEURONS = 30,
  parameter int DATA_WIDTH  = 16,
  parameter int TIMEOUT     = 64
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [DATA_WIDTH-1:0]             in_data,
  output logic                              nrn_in_valid,
  output logic [DATA_WIDTH-1:0]             nrn_in,
  input  logic [NUM_NEURONS-1:0]            nrn_out_valid,
  input  logic [NUM_NEURONS*DATA_WIDTH-1:0] nrn_out,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [DATA_WIDTH-1:0]             out_data,
  output logic                              out_last,
  output logic                              busy,
  output logic                              err_timeout
);

  localparam int IW = (IN_SIZE > 1) ? $clog2(IN_SIZE) : 1;
  localparam int NW = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [IW-1:0] LD_LAST  = IW'(IN_SIZE - 1);
  localparam logic [NW-1:0] NR_LAST  = NW'(NUM_NEURONS - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_LOAD,
    S_BCAST,
    S_WAIT,
    S_DRAIN
  } state_t;

  state_t state;

  logic [DATA_WIDTH-1:0]  vec_buf [IN_SIZE];
  logic [DATA_WIDTH-1:0]  res     [NUM_NEURONS];
  logic [DATA_WIDTH-1:0]  res_nxt [NUM_NEURONS];
  logic [NUM_NEURONS-1:0] mask;
  logic [NUM_NEURONS-1:0] mask_nxt;
  logic [IW-1:0]          ld_cnt;
  logic [IW-1:0]          bc_cnt;
  logic [IW-1:0]          bc_nxt;
  logic [NW-1:0]          dr_cnt;
  logic [NW-1:0]          dr_nxt;
  logic [TW-1:0]          tmo_cnt;
  logic [DATA_WIDTH-1:0]  first_word;
  logic                   load_accept;

  assign load_accept = (state == S_LOAD) && in_valid && in_ready;
  assign bc_nxt      = bc_cnt + 1'b1;
  assign dr_nxt      = dr_cnt + 1'b1;

  // With a one-word vector the first broadcast word is still on in_data.
  assign first_word = (IN_SIZE == 1) ? in_data : vec_buf[0];

  // Merge this cycle's neuron pulses so a completing pulse is seen at once.
  always_comb begin
    mask_nxt = mask | nrn_out_valid;
    for (int i = 0; i < NUM_NEURONS; i++) begin
      res_nxt[i] = nrn_out_valid[i] ? nrn_out[i*DATA_WIDTH +: DATA_WIDTH] : res[i];
    end
  end

  // The vector buffer is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (load_accept) begin
      vec_buf[ld_cnt] <= in_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_LOAD;
      ld_cnt       <= '0;
      bc_cnt       <= '0;
      dr_cnt       <= '0;
      tmo_cnt      <= '0;
      mask         <= '0;
      in_ready     <= 1'b1;
      nrn_in_valid <= 1'b0;
      nrn_in       <= '0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_last     <= 1'b0;
      busy         <= 1'b0;
      err_timeout  <= 1'b0;
      for (int i = 0; i < NUM_NEURONS; i++) begin
        res[i] <= '0;
      end
    end else begin
      case (state)
        S_LOAD: begin
          if (load_accept) begin
            if (ld_cnt == LD_LAST) begin
              ld_cnt       <= '0;
              in_ready     <= 1'b0;
              busy         <= 1'b1;
              nrn_in_valid <= 1'b1;
              nrn_in       <= first_word;
              bc_cnt       <= '0;
              state        <= S_BCAST;
            end else begin
              ld_cnt <= ld_cnt + 1'b1;
            end
          end
        end

        S_BCAST: begin
          if (bc_cnt == LD_LAST) begin
            bc_cnt       <= '0;
            nrn_in_valid <= 1'b0;
            mask         <= '0;
            tmo_cnt      <= '0;
            for (int i = 0; i < NUM_NEURONS; i++) begin
              res[i] <= '0;
            end
            state <= S_WAIT;
          end else begin
            bc_cnt <= bc_nxt;
            nrn_in <= vec_buf[bc_nxt];
          end
        end

        S_WAIT: begin
          mask <= mask_nxt;
          for (int i = 0; i < NUM_NEURONS; i++) begin
            res[i] <= res_nxt[i];
          end
          // A full mask wins over a timeout that lands on the same cycle.
          if ((&mask_nxt) || (tmo_cnt == TMO_LAST)) begin
            if (!(&mask_nxt)) begin
              err_timeout <= 1'b1;
            end
            dr_cnt    <= '0;
            out_valid <= 1'b1;
            out_data  <= res_nxt[0];
            out_last  <= (NR_LAST == '0);
            state     <= S_DRAIN;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end

        S_DRAIN: begin
          if (out_valid && out_ready) begin
            if (dr_cnt == NR_LAST) begin
              dr_cnt    <= '0;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              in_ready  <= 1'b1;
              busy      <= 1'b0;
              state     <= S_LOAD;
            end else begin
              dr_cnt   <= dr_nxt;
              out_data <= res[dr_nxt];
              out_last <= (dr_nxt == NR_LAST);
            end
          end
        end

        default: state <= S_LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_layer_sequencer.sv
// Directed bench for layer_sequencer with a 4-word vector, 3 neurons and a
// 16-cycle wait timeout; every expected value is hand-computed.
module tb_layer_sequencer;

  localparam int IN_SIZE     = 4;
  localparam int NUM_NEURONS = 3;
  localparam int DATA_WIDTH  = 16;
  localparam int TIMEOUT     = 16;

  logic                              clk;
  logic                              rst;
  logic                              in_valid;
  logic                              in_ready;
  logic [DATA_WIDTH-1:0]             in_data;
  logic                              nrn_in_valid;
  logic [DATA_WIDTH-1:0]             nrn_in;
  logic [NUM_NEURONS-1:0]            nrn_out_valid;
  logic [NUM_NEURONS*DATA_WIDTH-1:0] nrn_out;
  logic                              out_valid;
  logic                              out_ready;
  logic [DATA_WIDTH-1:0]             out_data;
  logic                              out_last;
  logic                              busy;
  logic                              err_timeout;

  int vecCount  = 0;
  int missCount = 0;

  layer_sequencer #(
    .IN_SIZE     (IN_SIZE),
    .NUM_NEURONS (NUM_NEURONS),
    .DATA_WIDTH  (DATA_WIDTH),
    .TIMEOUT     (TIMEOUT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .nrn_in_valid  (nrn_in_valid),
    .nrn_in        (nrn_in),
    .nrn_out_valid (nrn_out_valid),
    .nrn_out       (nrn_out),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_last      (out_last),
    .busy          (busy),
    .err_timeout   (err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vecCount++;
    assert (observed === expected)
    else begin
      missCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Loads a full vector back-to-back and follows the broadcast into WAIT.
  task automatic applyStimulus(input logic [15:0] w0, input logic [15:0] w1,
                               input logic [15:0] w2, input logic [15:0] w3);
    logic [15:0] w [4];
    w = '{w0, w1, w2, w3};
    for (int k = 0; k < 4; k++) begin
      checkOutput("load_in_ready", in_ready, 1);
      in_valid = 1'b1;
      in_data  = w[k];
      tick();
    end
    in_valid = 1'b0;
    in_data  = '0;
    checkOutput("bcast_in_ready", in_ready, 0);
    for (int k = 0; k < 4; k++) begin
      checkOutput("bcast_valid", nrn_in_valid, 1);
      checkOutput("bcast_word", nrn_in, w[k]);
      checkOutput("bcast_busy", busy, 1);
      tick();
    end
    checkOutput("bcast_end_valid", nrn_in_valid, 0);
    checkOutput("bcast_end_hold", nrn_in, w[3]);
    checkOutput("wait_in_ready", in_ready, 0);
  endtask

  // Expects a freshly entered DRAIN with out_ready held high.
  task automatic checkDrain(input logic [15:0] d0, input logic [15:0] d1,
                            input logic [15:0] d2);
    logic [15:0] d [3];
    d = '{d0, d1, d2};
    for (int k = 0; k < 3; k++) begin
      checkOutput("drain_valid", out_valid, 1);
      checkOutput("drain_data", out_data, d[k]);
      checkOutput("drain_last", out_last, (k == 2) ? 1 : 0);
      tick();
    end
    checkOutput("drain_end_valid", out_valid, 0);
    checkOutput("drain_end_in_ready", in_ready, 1);
    checkOutput("drain_end_busy", busy, 0);
  endtask

  initial begin
    rst           = 1'b1;
    in_valid      = 1'b0;
    in_data       = '0;
    nrn_out_valid = '0;
    nrn_out       = '0;
    out_ready     = 1'b0;
    repeat (3) tick();

    checkOutput("rst_in_ready", in_ready, 1);
    checkOutput("rst_nrn_valid", nrn_in_valid, 0);
    checkOutput("rst_nrn_in", nrn_in, 0);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_out_data", out_data, 0);
    checkOutput("rst_out_last", out_last, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_err", err_timeout, 0);
    rst = 1'b0;
    tick();

    $display("[TB] load/broadcast and all-at-once results");
    applyStimulus(16'd1, 16'd2, 16'd3, 16'd4);
    out_ready     = 1'b1;
    nrn_out       = {16'd30, 16'd20, 16'd10};
    nrn_out_valid = 3'b111;
    tick();
    nrn_out_valid = '0;
    checkDrain(16'd10, 16'd20, 16'd30);
    checkOutput("s2_err", err_timeout, 0);

    $display("[TB] out-of-order result arrival");
    applyStimulus(16'd5, 16'd6, 16'd7, 16'd8);
    nrn_out       = {16'd31, 16'd21, 16'd11};
    nrn_out_valid = 3'b010;
    tick();
    nrn_out_valid = 3'b001;
    checkOutput("s3_no_out_1", out_valid, 0);
    tick();
    nrn_out_valid = 3'b100;
    checkOutput("s3_no_out_2", out_valid, 0);
    tick();
    nrn_out_valid = '0;
    checkDrain(16'd11, 16'd21, 16'd31);
    checkOutput("s3_err", err_timeout, 0);

    $display("[TB] downstream backpressure");
    applyStimulus(16'h11, 16'h22, 16'h33, 16'h44);
    out_ready     = 1'b0;
    nrn_out       = {16'h0303, 16'h0202, 16'h0101};
    nrn_out_valid = 3'b111;
    tick();
    nrn_out_valid = '0;
    checkOutput("s4_data0", out_data, 16'h0101);
    tick();
    checkOutput("s4_hold0", out_data, 16'h0101);
    checkOutput("s4_hold0_last", out_last, 0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checkOutput("s4_data1", out_data, 16'h0202);
    repeat (2) tick();
    checkOutput("s4_hold1", out_data, 16'h0202);
    checkOutput("s4_hold1_last", out_last, 0);
    checkOutput("s4_hold1_valid", out_valid, 1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checkOutput("s4_data2", out_data, 16'h0303);
    checkOutput("s4_last2", out_last, 1);
    tick();
    checkOutput("s4_hold2", out_data, 16'h0303);
    checkOutput("s4_hold2_last", out_last, 1);
    checkOutput("s4_hold2_valid", out_valid, 1);
    out_ready = 1'b1;
    tick();
    checkOutput("s4_end_valid", out_valid, 0);
    checkOutput("s4_end_in_ready", in_ready, 1);

    $display("[TB] wait timeout with one result");
    applyStimulus(16'd9, 16'd9, 16'd9, 16'd9);
    nrn_out       = {16'h5555, 16'h5555, 16'd7};
    nrn_out_valid = 3'b001;
    tick();
    nrn_out_valid = '0;
    checkOutput("s5_early_valid", out_valid, 0);
    checkOutput("s5_early_err", err_timeout, 0);
    repeat (14) tick();
    checkOutput("s5_pre_tmo_valid", out_valid, 0);
    checkOutput("s5_pre_tmo_err", err_timeout, 0);
    checkOutput("s5_pre_tmo_busy", busy, 1);
    tick();
    checkOutput("s5_err_set", err_timeout, 1);
    checkDrain(16'd7, 16'd0, 16'd0);
    checkOutput("s5_err_sticky", err_timeout, 1);

    $display("[TB] reset during broadcast");
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1;
      in_data  = 16'(100 + k);
      tick();
    end
    in_valid = 1'b0;
    checkOutput("s6_err_kept", err_timeout, 1);
    checkOutput("s6_word0", nrn_in, 100);
    tick();
    checkOutput("s6_word1", nrn_in, 101);
    rst = 1'b1;
    #1;
    checkOutput("s6_rst_nrn_valid", nrn_in_valid, 0);
    checkOutput("s6_rst_in_ready", in_ready, 1);
    checkOutput("s6_rst_busy", busy, 0);
    checkOutput("s6_rst_err", err_timeout, 0);
    checkOutput("s6_rst_out_valid", out_valid, 0);
    tick();
    rst = 1'b0;
    tick();
    applyStimulus(16'd1, 16'd2, 16'd3, 16'd4);
    nrn_out       = {16'd3, 16'd2, 16'd1};
    nrn_out_valid = 3'b111;
    tick();
    nrn_out_valid = '0;
    checkDrain(16'd1, 16'd2, 16'd3);
    checkOutput("s6_final_err", err_timeout, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
